// File: rtl/hier_node_sequencer.sv
// Hierarchy node: launches enabled children sequentially or in parallel, supervises them
// with a watchdog and aggregates their completion/failure into a single child-like interface.
module hier_node_sequencer #(
    parameter int NUM_CHILDREN = 5,
    parameter int TIMEOUT_W    = 16,
    parameter int IDX_W        = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    mode_i,
    input  logic [NUM_CHILDREN-1:0] enable_mask_i,
    input  logic [TIMEOUT_W-1:0]    timeout_i,
    output logic [NUM_CHILDREN-1:0] child_start_o,
    input  logic [NUM_CHILDREN-1:0] child_done_i,
    input  logic [NUM_CHILDREN-1:0] child_err_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [NUM_CHILDREN-1:0] fail_mask_o,
    output logic [IDX_W-1:0]        cur_child_o
);
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FINISH} state_t;

    state_t                  r_state;
    logic                    r_mode;
    logic [NUM_CHILDREN-1:0] r_remain;
    logic [NUM_CHILDREN-1:0] r_pend;
    logic [TIMEOUT_W-1:0]    r_tmo;
    logic [TIMEOUT_W-1:0]    r_timer;
    logic [NUM_CHILDREN-1:0] r_child_start;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic [NUM_CHILDREN-1:0] r_fail;
    logic [IDX_W-1:0]        r_cur;

    logic [NUM_CHILDREN-1:0] w_low_bit;
    logic [IDX_W-1:0]        w_low_idx;
    logic [NUM_CHILDREN-1:0] w_valid;
    logic [NUM_CHILDREN-1:0] w_seen;
    logic [NUM_CHILDREN-1:0] w_bad;
    logic [NUM_CHILDREN-1:0] w_pend_left;
    logic                    w_expired;

    assign w_low_bit = r_remain & ((~r_remain) + NUM_CHILDREN'(1));

    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_CHILDREN - 1; i >= 0; i--) begin
            if (r_remain[i]) w_low_idx = IDX_W'(i);
        end
    end

    // A child's inputs are ignored while its own start pulse is still on the wire.
    assign w_valid     = r_pend & ~r_child_start;
    assign w_seen      = w_valid & (child_done_i | child_err_i);
    assign w_bad       = w_valid & child_err_i;
    assign w_pend_left = r_pend & ~w_seen;
    assign w_expired   = (r_tmo != '0) && (r_timer == (r_tmo - TIMEOUT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_mode        <= 1'b0;
            r_remain      <= '0;
            r_pend        <= '0;
            r_tmo         <= '0;
            r_timer       <= '0;
            r_child_start <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_fail        <= '0;
            r_cur         <= '0;
        end else begin
            r_child_start <= '0;
            r_done        <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start_i && !abort_i) begin
                    r_mode   <= mode_i;
                    r_remain <= enable_mask_i;
                    r_tmo    <= timeout_i;
                    r_fail   <= '0;
                    r_err    <= 1'b0;
                    r_busy   <= 1'b1;
                    r_cur    <= '0;
                    r_state  <= S_LAUNCH;
                end
            end else if (abort_i) begin
                // Abort wins over any completion seen in the same cycle.
                r_fail   <= r_fail | r_pend;
                r_err    <= 1'b1;
                r_busy   <= 1'b0;
                r_cur    <= '0;
                r_pend   <= '0;
                r_remain <= '0;
                r_timer  <= '0;
                r_state  <= S_IDLE;
            end else begin
                case (r_state)
                    S_LAUNCH: begin
                        r_timer <= '0;
                        if (r_remain == '0) begin
                            r_state <= S_FINISH;
                        end else if (r_mode) begin
                            r_child_start <= r_remain;
                            r_pend        <= r_remain;
                            r_remain      <= '0;
                            r_state       <= S_WAIT;
                        end else begin
                            r_child_start <= w_low_bit;
                            r_pend        <= w_low_bit;
                            r_remain      <= r_remain & ~w_low_bit;
                            r_cur         <= w_low_idx;
                            r_state       <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if ((r_tmo != '0) && (r_timer != '1)) r_timer <= r_timer + TIMEOUT_W'(1);
                        r_fail <= r_fail | w_bad;
                        r_pend <= w_pend_left;
                        // A response in the expiring cycle still counts; only silent children time out.
                        if ((w_pend_left == '0) || w_expired) begin
                            if (w_expired) r_fail <= r_fail | w_bad | w_pend_left;
                            r_pend  <= '0;
                            r_state <= (r_mode || (r_remain == '0)) ? S_FINISH : S_LAUNCH;
                        end
                    end
                    S_FINISH: begin
                        r_done  <= 1'b1;
                        r_err   <= |r_fail;
                        r_busy  <= 1'b0;
                        r_cur   <= '0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign child_start_o = r_child_start;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign error_o       = r_err;
    assign fail_mask_o   = r_fail;
    assign cur_child_o   = r_cur;
endmodule

// File: tb/tb_hier_node_sequencer.sv
// Bench for hier_node_sequencer: run-level reference model compared every cycle,
// scripted child responders for directed scenarios, then randomized runs.
module tb_hier_node_sequencer;
    localparam int NC = 5;
    localparam int TW = 16;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          mode_i = 1'b0;
    logic [NC-1:0] mask_i = '0;
    logic [TW-1:0] timeout_i = '0;
    logic [NC-1:0] child_done_i = '0;
    logic [NC-1:0] child_err_i = '0;
    logic [NC-1:0] child_start_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [NC-1:0] fail_mask_o;
    logic [IW-1:0] cur_child_o;

    hier_node_sequencer #(.NUM_CHILDREN(NC), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .mode_i(mode_i),
        .enable_mask_i(mask_i), .timeout_i(timeout_i), .child_start_o(child_start_o),
        .child_done_i(child_done_i), .child_err_i(child_err_i), .busy_o(busy_o),
        .done_o(done_o), .error_o(error_o), .fail_mask_o(fail_mask_o), .cur_child_o(cur_child_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    // Responder configuration
    bit            rnd_mode = 1'b0;
    bit            allow_silent = 1'b0;
    bit            spur_en = 1'b0;
    int            fix_kind[NC];
    int            fix_del[NC];
    int            resp_at[NC];
    int            resp_kind[NC];
    logic [NC-1:0] extra_done = '0;

    // Observation logs
    logic [NC-1:0] st_val[$];
    int            st_cyc[$];
    int            done_cnt = 0;
    int            done_cyc = 0;

    // Reference model: expected outputs plus run bookkeeping
    logic [NC-1:0] e_start = '0;
    logic [NC-1:0] e_fail = '0;
    logic          e_busy = 1'b0;
    logic          e_done = 1'b0;
    logic          e_err = 1'b0;
    logic [IW-1:0] e_cur = '0;
    bit            m_run = 1'b0;
    bit            m_par = 1'b0;
    bit            m_launch = 1'b0;
    bit            m_wrap = 1'b0;
    int            m_order[$];
    logic [NC-1:0] m_set = '0;
    logic [NC-1:0] m_out = '0;
    logic [NC-1:0] m_prev = '0;
    int            m_waited = 0;
    int            m_tmo = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_start = '0; e_fail = '0; e_busy = 0; e_done = 0; e_err = 0; e_cur = '0;
            m_run = 0; m_launch = 0; m_wrap = 0; m_out = '0; m_order.delete();
        end else begin
            logic [NC-1:0] live;
            logic [NC-1:0] answered;
            int k;
            m_prev  = e_start;
            e_start = '0;
            e_done  = 1'b0;
            if (!m_run) begin
                if (start_i && !abort_i) begin
                    m_run = 1; m_par = mode_i; m_set = mask_i; m_tmo = int'(timeout_i);
                    m_order.delete();
                    for (int i = 0; i < NC; i++) if (mask_i[i]) m_order.push_back(i);
                    m_launch = 1; m_wrap = 0; m_out = '0;
                    e_busy = 1; e_fail = '0; e_err = 0; e_cur = '0;
                end
            end else if (abort_i) begin
                e_fail = e_fail | m_out; e_err = 1; e_busy = 0; e_cur = '0;
                m_run = 0; m_out = '0; m_launch = 0; m_wrap = 0;
            end else if (m_wrap) begin
                e_done = 1; e_err = (e_fail != '0); e_busy = 0; e_cur = '0;
                m_run = 0; m_wrap = 0;
            end else if (m_launch) begin
                m_launch = 0; m_waited = 0;
                if (m_order.size() == 0) m_wrap = 1;
                else if (m_par) begin
                    e_start = m_set; m_out = m_set; m_order.delete();
                end else begin
                    k = m_order.pop_front();
                    e_start[k] = 1'b1; m_out = '0; m_out[k] = 1'b1; e_cur = IW'(k);
                end
            end else begin
                live     = m_out & ~m_prev;
                answered = live & (child_done_i | child_err_i);
                e_fail   = e_fail | (live & child_err_i);
                m_out    = m_out & ~answered;
                if (m_out != '0 && m_tmo != 0 && m_waited == m_tmo - 1) begin
                    e_fail = e_fail | m_out;
                    m_out  = '0;
                end
                m_waited++;
                if (m_out == '0) begin
                    if (m_par || m_order.size() == 0) m_wrap = 1;
                    else m_launch = 1;
                end
            end
        end
    end

    // Monitor, per-cycle compare and child responder share one process to keep ordering fixed.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (child_start_o != '0) begin
                st_val.push_back(child_start_o);
                st_cyc.push_back(cyc);
            end
            if (done_o === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cmp_en) begin
                chk("child_start", child_start_o, e_start);
                chk("busy", busy_o, e_busy);
                chk("done", done_o, e_done);
                chk("error", error_o, e_err);
                chk("fail_mask", fail_mask_o, e_fail);
                chk("cur_child", cur_child_o, e_cur);
            end
            child_done_i = extra_done;
            child_err_i  = '0;
            if (spur_en) begin
                child_done_i = child_done_i | (NC'($urandom) & NC'($urandom) & NC'($urandom));
                child_err_i  = NC'($urandom) & NC'($urandom) & NC'($urandom) & NC'($urandom);
            end
            for (int i = 0; i < NC; i++) begin
                if (child_start_o[i] === 1'b1) begin
                    if (rnd_mode) begin
                        resp_kind[i] = allow_silent ? $urandom_range(0, 3) : $urandom_range(0, 2);
                        resp_at[i]   = cyc + (allow_silent ? $urandom_range(0, 6) : $urandom_range(1, 6));
                    end else begin
                        resp_kind[i] = fix_kind[i];
                        resp_at[i]   = cyc + fix_del[i];
                    end
                end
            end
            for (int i = 0; i < NC; i++) begin
                if (resp_at[i] == cyc) begin
                    if (resp_kind[i] == 0 || resp_kind[i] == 2) child_done_i[i] = 1'b1;
                    if (resp_kind[i] == 1 || resp_kind[i] == 2) child_err_i[i] = 1'b1;
                    resp_at[i] = -1;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        st_val.delete();
        st_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic set_fix(input int i, input int k, input int d);
        fix_kind[i] = k;
        fix_del[i]  = d;
    endtask

    task automatic launch(input bit md, input logic [NC-1:0] mk, input logic [TW-1:0] to);
        mode_i = md; mask_i = mk; timeout_i = to; start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        chk(nm, busy_o, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        int n;
        for (int i = 0; i < NC; i++) begin
            resp_at[i] = -1; resp_kind[i] = 3; set_fix(i, 3, 1);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;
        step();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_fail", fail_mask_o, 0);
        chk("rst_start", child_start_o, 0);
        chk("rst_cur", cur_child_o, 0);

        // Sequential 10101, no watchdog, each child done 3 cycles after its start
        clear_logs();
        for (int i = 0; i < NC; i++) set_fix(i, 0, 3);
        launch(1'b0, 5'b10101, '0);
        wait_idle("t1_end", 200);
        repeat (3) step();
        chk("t1_nstarts", st_val.size(), 3);
        if (st_val.size() == 3) begin
            chk("t1_start0", st_val[0], 5'b00001);
            chk("t1_start1", st_val[1], 5'b00100);
            chk("t1_start2", st_val[2], 5'b10000);
            chk("t1_gap", st_cyc[1] - st_cyc[0], 5);
        end
        chk("t1_ndone", done_cnt, 1);
        chk("t1_error", error_o, 0);
        chk("t1_fail", fail_mask_o, 0);

        // Parallel 11111: children 1,3 fail; 0 and 4 finish together
        clear_logs();
        set_fix(0, 0, 3); set_fix(1, 1, 2); set_fix(2, 0, 4); set_fix(3, 1, 5); set_fix(4, 0, 3);
        launch(1'b1, 5'b11111, '0);
        wait_idle("t2_end", 200);
        repeat (2) step();
        chk("t2_nstarts", st_val.size(), 1);
        if (st_val.size() == 1) chk("t2_start", st_val[0], 5'b11111);
        chk("t2_ndone", done_cnt, 1);
        chk("t2_fail", fail_mask_o, 5'b01010);
        chk("t2_error", error_o, 1);

        // Sequential 00011, watchdog 4: child 0 silent, child 1 done
        clear_logs();
        set_fix(0, 3, 1); set_fix(1, 0, 2);
        launch(1'b0, 5'b00011, 16'd4);
        wait_idle("t3_end", 200);
        repeat (2) step();
        chk("t3_nstarts", st_val.size(), 2);
        if (st_val.size() == 2) chk("t3_gap", st_cyc[1] - st_cyc[0], 5);
        chk("t3_fail", fail_mask_o, 5'b00001);
        chk("t3_error", error_o, 1);

        // Parallel: child 2 done+err together, spurious done on disabled child 3
        clear_logs();
        set_fix(0, 0, 3); set_fix(1, 0, 3); set_fix(2, 2, 2); set_fix(4, 0, 3);
        launch(1'b1, 5'b10111, '0);
        extra_done = 5'b01000;
        repeat (3) step();
        extra_done = '0;
        wait_idle("t4_end", 200);
        repeat (2) step();
        if (st_val.size() >= 1) chk("t4_start", st_val[0], 5'b10111);
        chk("t4_fail", fail_mask_o, 5'b00100);
        chk("t4_ndone", done_cnt, 1);

        // Empty mask with start held high through the run
        clear_logs();
        mode_i = 1'b0; mask_i = '0; timeout_i = '0; start_i = 1'b1;
        t0 = cyc;
        repeat (3) step();
        start_i = 1'b0;
        repeat (4) step();
        chk("t5_ndone", done_cnt, 1);
        chk("t5_latency", done_cyc - t0, 3);
        chk("t5_nstarts", st_val.size(), 0);
        chk("t5_error", error_o, 0);

        // Abort while child 1 is active, then reset mid-run
        clear_logs();
        set_fix(0, 0, 2); set_fix(1, 3, 1);
        launch(1'b0, 5'b00011, '0);
        n = 0;
        while (st_val.size() < 2 && n < 60) begin
            step();
            n++;
        end
        chk("t6_child1_started", st_val.size(), 2);
        repeat (2) step();
        chk("t6_cur", cur_child_o, 1);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        repeat (2) step();
        chk("t6_ndone", done_cnt, 0);
        chk("t6_fail", fail_mask_o, 5'b00010);
        chk("t6_error", error_o, 1);
        chk("t6_busy", busy_o, 0);
        clear_logs();
        set_fix(0, 3, 1);
        launch(1'b1, 5'b00001, '0);
        repeat (3) step();
        chk("t6_busy_mid", busy_o, 1);
        rst_n = 1'b0;
        step();
        chk("t6r_busy", busy_o, 0);
        chk("t6r_done", done_o, 0);
        chk("t6r_error", error_o, 0);
        chk("t6r_fail", fail_mask_o, 0);
        chk("t6r_start", child_start_o, 0);
        chk("t6r_cur", cur_child_o, 0);
        rst_n = 1'b1;
        step();
        chk("t6r_ndone", done_cnt, 0);

        // Randomized runs
        rnd_mode = 1'b1;
        for (int r = 0; r < 60; r++) begin
            logic [TW-1:0] to;
            to = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 8));
            allow_silent = (to != '0);
            spur_en = $urandom_range(0, 1);
            mode_i = $urandom_range(0, 1);
            mask_i = ($urandom_range(0, 5) == 0) ? '0 : NC'($urandom);
            timeout_i = to;
            start_i = 1'b1;
            abort_i = ($urandom_range(0, 9) == 0);
            step();
            start_i = 1'b0;
            abort_i = 1'b0;
            n = 0;
            while (busy_o !== 1'b0 && n < 400) begin
                start_i   = ($urandom_range(0, 3) == 0);
                abort_i   = ($urandom_range(0, 59) == 0);
                mode_i    = $urandom_range(0, 1);
                mask_i    = NC'($urandom);
                timeout_i = TW'($urandom_range(0, 8));
                step();
                n++;
            end
            start_i = 1'b0;
            abort_i = 1'b0;
            chk("rnd_run_end", busy_o, 0);
            repeat ($urandom_range(1, 3)) step();
        end
        spur_en = 1'b0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
